// File: rtl/hamming_tx_pkg.sv
// hamming_tx_pkg
// Shared types, widths and the Hamming(7,4) encode function for the transmit
// encoder. The encode function is also meant for decoder-side checkers.
//   tx_state_t        : serial framer state
//   CW_W / DATA_W     : codeword and data widths
//   hamming74_encode  : 4-bit data -> 7-bit codeword {d4,d3,d2,p4,d1,p2,p1}
//   inject_mask       : 0 -> no flip, n (1..7) -> one-hot on codeword bit n-1
package hamming_tx_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  function automatic logic [CW_W-1:0] inject_mask(input logic [2:0] sel);
    logic [CW_W-1:0] m;
    if (sel == 3'd0) m = '0;
    else             m = 7'd1 << (sel - 3'd1);
    return m;
  endfunction

endpackage

// File: rtl/hamming_tx_fifo2.sv
// hamming_tx_fifo2
// Two-entry register FIFO, synchronous active-low reset.
//   clock, reset_n : clock / sync reset
//   i_push, i_wdata: write strobe and data (caller must not push when full)
//   i_pop, o_rdata : read strobe and head data (valid when not empty)
//   o_full, o_empty, o_count : occupancy derived from the registered count
module hamming_tx_fifo2 #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [0:1];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/hamming_tx_encoder.sv
// hamming_tx_encoder
// Buffers 4-bit words, Hamming(7,4)-encodes them (with optional single-bit
// error injection) and sends each codeword as a start/7 data/stop serial frame.
//   clock, reset_n : clock / sync active-low reset
//   in_valid/in_ready/in_data/in_inject : input handshake, nibble, flip select
//   code_out    : codeword of the current or last frame
//   tx_out      : serial line, idle high, LSB first, DIV clocks per bit
//   tx_busy     : frame in progress
//   frame_count : completed frames, wraps at 256
//
// state | meaning
// IDLE  | line high, waiting for a buffered word
// START | line low for DIV clocks
// DATA  | codeword bits 0..6, DIV clocks each
// STOP  | line high for DIV clocks; chains straight into START if a word waits
module hamming_tx_encoder
  import hamming_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_inject,
  output logic [CW_W-1:0]   code_out,
  output logic              tx_out,
  output logic              tx_busy,
  output logic [7:0]        frame_count
);

  localparam logic [7:0] DIV_M1   = 8'(DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'd6;

  tx_state_t       r_state;
  logic [7:0]      r_div;
  logic [2:0]      r_bit;
  logic [CW_W-1:0] r_shift;
  logic            r_tx;
  logic [CW_W-1:0] r_code;
  logic [7:0]      r_fc;
  logic            r_in_ready;

  tx_state_t       w_state_nxt;
  logic [7:0]      w_div_nxt;
  logic [2:0]      w_bit_nxt;
  logic [CW_W-1:0] w_shift_nxt;
  logic            w_tx_nxt;
  logic            w_pop;
  logic            w_push;
  logic            w_fc_inc;
  logic            w_ready_nxt;
  logic [CW_W-1:0] w_cw;
  logic [DATA_W+2:0] w_rdata;
  logic            w_full;
  logic            w_empty;
  logic [1:0]      w_count;

  assign w_push = in_valid & r_in_ready;

  hamming_tx_fifo2 #(.W(DATA_W + 3)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata ({in_inject, in_data}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_cw = hamming74_encode(w_rdata[DATA_W-1:0]) ^ inject_mask(w_rdata[DATA_W+2:DATA_W]);

  // Ready is the registered inverse of next-cycle fullness.
  assign w_ready_nxt = !((w_full | ((w_count == 2'd1) & w_push)) & !w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_div_nxt   = DIV_M1;
          w_tx_nxt    = 1'b0;
          w_shift_nxt = w_cw;
        end
      end
      START: begin
        if (r_div != 8'd0) begin
          w_div_nxt = r_div - 8'd1;
        end else begin
          w_state_nxt = DATA;
          w_div_nxt   = DIV_M1;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[CW_W-1:1]};
        end
      end
      DATA: begin
        if (r_div != 8'd0) begin
          w_div_nxt = r_div - 8'd1;
        end else if (r_bit == LAST_BIT) begin
          w_state_nxt = STOP;
          w_div_nxt   = DIV_M1;
          w_tx_nxt    = 1'b1;
        end else begin
          w_div_nxt   = DIV_M1;
          w_bit_nxt   = r_bit + 3'd1;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[CW_W-1:1]};
        end
      end
      STOP: begin
        if (r_div != 8'd0) begin
          w_div_nxt = r_div - 8'd1;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_div_nxt   = DIV_M1;
          w_tx_nxt    = 1'b0;
          w_shift_nxt = w_cw;
        end else begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // The frame is counted on the edge that begins the final stop-bit clock.
  assign w_fc_inc = (w_state_nxt == STOP) && (w_div_nxt == 8'd0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_div      <= 8'd0;
      r_bit      <= 3'd0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_code     <= '0;
      r_fc       <= 8'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_in_ready <= w_ready_nxt;
      if (w_pop)    r_code <= w_cw;
      if (w_fc_inc) r_fc   <= r_fc + 8'd1;
    end
  end

  assign in_ready    = r_in_ready;
  assign code_out    = r_code;
  assign tx_out      = r_tx;
  assign tx_busy     = (r_state != IDLE);
  assign frame_count = r_fc;

endmodule

// File: tb/tb_hamming_tx_encoder.sv
// tb_hamming_tx_encoder
// Directed bench: encode table on a DIV=1 instance, frame timing, backpressure,
// mid-frame reset on a DIV=4 instance, and frame counter wrap at DIV=1.
module tb_hamming_tx_encoder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // instance A: DIV = 1
  logic       a_rst_n, a_valid, a_rdy, a_tx, a_busy;
  logic [3:0] a_data;
  logic [2:0] a_inj;
  logic [6:0] a_code;
  logic [7:0] a_fc;
  // instance B: DIV = 4
  logic       b_rst_n, b_valid, b_rdy, b_tx, b_busy;
  logic [3:0] b_data;
  logic [2:0] b_inj;
  logic [6:0] b_code;
  logic [7:0] b_fc;

  hamming_tx_encoder #(.DIV(1)) u_a (
    .clock(clock), .reset_n(a_rst_n), .in_valid(a_valid), .in_ready(a_rdy),
    .in_data(a_data), .in_inject(a_inj), .code_out(a_code), .tx_out(a_tx),
    .tx_busy(a_busy), .frame_count(a_fc)
  );

  hamming_tx_encoder #(.DIV(4)) u_b (
    .clock(clock), .reset_n(b_rst_n), .in_valid(b_valid), .in_ready(b_rdy),
    .in_data(b_data), .in_inject(b_inj), .code_out(b_code), .tx_out(b_tx),
    .tx_busy(b_busy), .frame_count(b_fc)
  );

  typedef struct {
    logic [3:0] data;
    logic [2:0] inj;
    logic [6:0] cw;
  } vec_t;

  vec_t vecs [8];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_fc_a = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Independent syndrome decoder: positions 1..7 map to codeword bits 0..6.
  function automatic logic [3:0] decode(input logic [6:0] c);
    logic [2:0] syn;
    logic [6:0] f;
    syn[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    syn[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    syn[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    f = c;
    if (syn != 3'd0) f[syn - 3'd1] = ~f[syn - 3'd1];
    return {f[6], f[5], f[4], f[2]};
  endfunction

  task automatic wait_ready_a();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (a_rdy) return;
    end
    chk("ready_timeout_a", 0, 1);
  endtask

  task automatic wait_ready_b();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (b_rdy) return;
    end
    chk("ready_timeout_b", 0, 1);
  endtask

  task automatic push_b(input logic [3:0] d);
    wait_ready_b();
    b_valid = 1'b1; b_data = d; b_inj = 3'd0;
    @(posedge clock); #1;
    b_valid = 1'b0;
  endtask

  task automatic reset_a();
    @(negedge clock); a_rst_n = 1'b0; a_valid = 1'b0;
    @(negedge clock); a_rst_n = 1'b1;
    exp_fc_a = 0;
  endtask

  task automatic reset_b();
    @(negedge clock); b_rst_n = 1'b0; b_valid = 1'b0;
    @(negedge clock); b_rst_n = 1'b1;
  endtask

  // One word through the DIV=1 instance, capturing the 9-clock frame.
  task automatic send_a(input int idx);
    logic       rx [1:9];
    logic [6:0] rx_cw;
    logic [6:0] code;
    wait_ready_a();
    a_valid = 1'b1; a_data = vecs[idx].data; a_inj = vecs[idx].inj;
    @(posedge clock); #1;
    a_valid = 1'b0;
    code = '0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clock); #1;
      rx[e] = a_tx;
      if (e == 1) code = a_code;
      if (e == 8) chk($sformatf("v%0d_fc_before", idx), a_fc, exp_fc_a);
      if (e == 9) chk($sformatf("v%0d_fc_after", idx), a_fc, (exp_fc_a + 1) & 255);
    end
    exp_fc_a = (exp_fc_a + 1) & 255;
    for (int i = 0; i < 7; i++) rx_cw[i] = rx[i + 2];
    chk($sformatf("v%0d_start", idx), rx[1], 0);
    chk($sformatf("v%0d_code", idx), code, vecs[idx].cw);
    chk($sformatf("v%0d_serial", idx), rx_cw, vecs[idx].cw);
    chk($sformatf("v%0d_stop", idx), rx[9], 1);
    chk($sformatf("v%0d_decoded", idx), decode(code), vecs[idx].data);
  endtask

  initial begin
    logic [6:0] cw_b;
    logic [3:0] bp [4];
    int idx, busy_cnt, gap, acc, last, maxfc, hi_cnt;
    logic rs, seen, just3, ex;

    vecs[0] = '{4'h0, 3'd0, 7'b0000000};
    vecs[1] = '{4'h1, 3'd0, 7'b0000111};
    vecs[2] = '{4'hB, 3'd0, 7'b1010101};
    vecs[3] = '{4'hF, 3'd0, 7'b1111111};
    vecs[4] = '{4'h6, 3'd0, 7'b0110011};
    vecs[5] = '{4'hB, 3'd3, 7'b1010001};
    vecs[6] = '{4'h0, 3'd7, 7'b1000000};
    vecs[7] = '{4'hF, 3'd1, 7'b1111110};

    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0; a_inj = '0; b_inj = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_a_tx", a_tx, 1);     chk("rst_a_busy", a_busy, 0);
    chk("rst_a_code", a_code, 0); chk("rst_a_fc", a_fc, 0);
    chk("rst_b_tx", b_tx, 1);     chk("rst_b_busy", b_busy, 0);
    chk("rst_b_code", b_code, 0); chk("rst_b_fc", b_fc, 0);
    @(negedge clock); a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(posedge clock); #1;
    chk("rel_a_ready", a_rdy, 1); chk("rel_b_ready", b_rdy, 1);

    // encode table, DIV = 1
    for (int i = 0; i < 8; i++) send_a(i);

    // frame timing, DIV = 4, word 0xB
    cw_b = 7'b1010101;
    wait_ready_b();
    b_valid = 1'b1; b_data = 4'hB; b_inj = 3'd0;
    @(posedge clock); #1;
    b_valid = 1'b0;
    chk("ft_idle_at_k_busy", b_busy, 0);
    chk("ft_idle_at_k_tx", b_tx, 1);
    for (int e = 1; e <= 36; e++) begin
      int region;
      @(posedge clock); #1;
      region = (e - 1) / 4;
      if (region == 0)      ex = 1'b0;
      else if (region == 8) ex = 1'b1;
      else                  ex = cw_b[region - 1];
      chk($sformatf("ft_tx_e%0d", e), b_tx, ex);
      if (e == 1)  chk("ft_code", b_code, cw_b);
      if (e == 35) chk("ft_fc_e35", b_fc, 0);
      if (e == 36) chk("ft_fc_e36", b_fc, 1);
    end
    @(posedge clock); #1;
    chk("ft_busy_end", b_busy, 0);
    chk("ft_tx_end", b_tx, 1);

    // backpressure / back-to-back, DIV = 4
    reset_b();
    bp[0] = 4'h1; bp[1] = 4'h6; bp[2] = 4'hF; bp[3] = 4'hB;
    idx = 0; busy_cnt = 0; gap = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      b_valid = (idx < 4);
      b_data  = bp[(idx < 4) ? idx : 0];
      b_inj   = 3'd0;
      rs = b_rdy;
      @(posedge clock);
      just3 = 1'b0;
      if (b_valid && rs) begin
        idx++;
        just3 = (idx == 3);
      end
      #1;
      if (just3) chk("bp_ready_low_after_3", b_rdy, 0);
      if (b_busy) begin
        seen = 1'b1;
        busy_cnt++;
      end else if (seen && b_fc != 8'd4) begin
        gap++;
      end
      if (seen && !b_busy && idx == 4) break;
    end
    b_valid = 1'b0;
    chk("bp_accepted", idx, 4);
    chk("bp_busy_cycles", busy_cnt, 144);
    chk("bp_idle_gaps", gap, 0);
    chk("bp_fc", b_fc, 4);
    chk("bp_last_code", b_code, 7'b1010101);

    // reset during DATA of frame 2 with one word queued
    reset_b();
    push_b(4'h1);
    push_b(4'h6);
    push_b(4'hF);
    repeat (48) @(posedge clock);
    #1;
    chk("mr_pre_fc", b_fc, 1);
    chk("mr_pre_busy", b_busy, 1);
    @(negedge clock); b_rst_n = 1'b0;
    @(posedge clock); #1;
    chk("mr_tx", b_tx, 1);
    chk("mr_busy", b_busy, 0);
    chk("mr_fc", b_fc, 0);
    chk("mr_ready", b_rdy, 1);
    chk("mr_code", b_code, 0);
    @(negedge clock); b_rst_n = 1'b1;
    hi_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clock); #1;
      if (b_busy || !b_tx) hi_cnt++;
    end
    chk("mr_no_frame_after", hi_cnt, 0);
    chk("mr_fc_after", b_fc, 0);

    // counter wrap, 256 frames at DIV = 1
    reset_a();
    acc = 0; last = 0; maxfc = 0;
    for (int cyc = 0; cyc < 256 * 9 + 200; cyc++) begin
      @(negedge clock);
      a_valid = (acc < 256);
      a_data  = 4'(acc);
      a_inj   = 3'd0;
      rs = a_rdy;
      @(posedge clock);
      if (a_valid && rs) begin
        acc++;
        last = cyc;
      end
      #1;
      if (int'(a_fc) > maxfc) maxfc = int'(a_fc);
      if (acc == 256 && !a_busy && cyc > last + 2) break;
    end
    a_valid = 1'b0;
    chk("wrap_accepted", acc, 256);
    chk("wrap_max_fc", maxfc, 255);
    chk("wrap_fc_zero", a_fc, 0);
    chk("wrap_idle_tx", a_tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
